// File: rtl/hazard_stall_controller_if.sv
// Pipeline hazard bus: decoded per-stage control bits in, stage write/flush enables out.
interface hazard_stall_controller_if #(
   parameter int unsigned CNT_W = 8
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             id_jump;
   logic             ex_mem_read;
   logic [4:0]       ex_rt;
   logic             ex_branch_taken;
   logic             mem_access;
   logic             mem_ready;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_hold;
   logic             idex_bubble;
   logic             exmem_hold;
   logic             memwb_bubble;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
             ex_branch_taken, mem_access, mem_ready,
      input  pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
             exmem_hold, memwb_bubble, mem_timeout, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
             ex_branch_taken, mem_access, mem_ready,
      output pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
             exmem_hold, memwb_bubble, mem_timeout, stall_count
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// 5-stage MIPS sequencing: load-use stalls, branch/jump squashes, data-memory
// wait freezes with a sticky timeout. Stage controls are Mealy; flag and counter are registered.
module hazard_stall_controller #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned CNT_W        = 8
) (
   input logic                      clk,
   input logic                      rst_n,
   hazard_stall_controller_if.slave bus
);
   localparam logic [7:0]       WAIT_MAX = 8'(MEM_WAIT_MAX);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

   state_t           state, next_state;
   logic [7:0]       wait_cnt, wait_nxt;
   logic [CNT_W-1:0] stall_count;
   logic             mem_timeout;

   logic load_use, freeze_req, freeze;
   logic pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_bubble;

   assign freeze_req = bus.mem_access && !bus.mem_ready;
   assign load_use   = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                       ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

   // Next state and wait counter
   always_comb begin
      next_state = state;
      wait_nxt   = wait_cnt;
      freeze     = 1'b0;
      case (state)
         RUN: begin
            if (freeze_req) begin
               freeze     = 1'b1;
               next_state = MEM_WAIT;
               wait_nxt   = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (freeze_req) begin
               freeze = 1'b1;
               if (wait_cnt == WAIT_MAX) next_state = TIMEOUT;
               else                      wait_nxt   = wait_cnt + 8'd1;
            end else begin
               next_state = RUN;
               wait_nxt   = 8'd0;
            end
         end
         TIMEOUT: freeze = 1'b1;
         default: begin
            next_state = RUN;
            wait_nxt   = 8'd0;
         end
      endcase
   end

   // Stage enables; freeze outranks branch, branch outranks jump, jump masks load-use
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_hold    = 1'b0;
      idex_bubble  = 1'b0;
      exmem_hold   = 1'b0;
      memwb_bubble = 1'b0;
      if (!rst_n) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (freeze) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_hold    = 1'b1;
         exmem_hold   = 1'b1;
         memwb_bubble = 1'b1;
      end else if (bus.ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (bus.id_jump) begin
         ifid_flush = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         stall_count <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_nxt;
         if (next_state == TIMEOUT) mem_timeout <= 1'b1;
         if (!pc_write && (stall_count != CNT_SAT)) stall_count <= stall_count + CNT_W'(1);
      end
   end

   assign bus.pc_write     = pc_write;
   assign bus.ifid_write   = ifid_write;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.idex_hold    = idex_hold;
   assign bus.idex_bubble  = idex_bubble;
   assign bus.exmem_hold   = exmem_hold;
   assign bus.memwb_bubble = memwb_bubble;
   assign bus.mem_timeout  = mem_timeout;
   assign bus.stall_count  = stall_count;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: each driven cycle queues its expected enables, flag and counter;
// a negedge monitor pops and compares.
module tb_hazard_stall_controller;
   localparam int unsigned CNT_W = 8;

   // {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_bubble}
   localparam logic [6:0] DEF = 7'b1100000;
   localparam logic [6:0] FRZ = 7'b0001011;
   localparam logic [6:0] BR  = 7'b1110100;
   localparam logic [6:0] JMP = 7'b1110000;
   localparam logic [6:0] LU  = 7'b0000100;
   localparam logic [6:0] RST = 7'b0010101;

   typedef struct {
      string      tag;
      logic [6:0] ctl;
      logic       to;
      int         cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_cnt  = 0;
   exp_t sb[$];

   hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

   hazard_stall_controller #(.MEM_WAIT_MAX(4), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.tag, "_ctl"}, 32'({bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_hold,
                                   bus.idex_bubble, bus.exmem_hold, bus.memwb_bubble}), 32'(e.ctl));
         chk({e.tag, "_to"},  32'(bus.mem_timeout), 32'(e.to));
         chk({e.tag, "_cnt"}, 32'(bus.stall_count), 32'(e.cnt));
      end
   end

   // One cycle: drive inputs, queue expectations, advance past the edge.
   task automatic step(input string tag, input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic jump, input logic mrd, input logic [4:0] exrt,
                       input logic br, input logic ma, input logic mrdy,
                       input logic [6:0] ctl, input logic to);
      exp_t e;
      rst_n               = rst;
      bus.id_rs           = rs;
      bus.id_rt           = rt;
      bus.id_uses_rt      = uses_rt;
      bus.id_jump         = jump;
      bus.ex_mem_read     = mrd;
      bus.ex_rt           = exrt;
      bus.ex_branch_taken = br;
      bus.mem_access      = ma;
      bus.mem_ready       = mrdy;
      e.tag = tag; e.ctl = ctl; e.to = to; e.cnt = exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!rst)                            exp_cnt = 0;
      else if (!ctl[6] && exp_cnt < 255)   exp_cnt = exp_cnt + 1;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0; bus.id_jump = 1'b0;
      bus.ex_mem_read = 1'b0; bus.ex_rt = '0; bus.ex_branch_taken = 1'b0;
      bus.mem_access = 1'b0; bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      step("reset",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0);
      step("idle",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
      step("lu_rs",      1, 5, 0, 0, 0, 1, 5, 0, 0, 0, LU,  0);
      step("lu_clear",   1, 5, 0, 0, 0, 0, 5, 0, 0, 0, DEF, 0);
      step("lu_r0",      1, 0, 0, 0, 0, 1, 0, 0, 0, 0, DEF, 0);
      step("rt_nouse",   1, 3, 7, 0, 0, 1, 7, 0, 0, 0, DEF, 0);
      step("rt_use",     1, 3, 7, 1, 0, 1, 7, 0, 0, 0, LU,  0);
      step("br_over_lu", 1, 5, 0, 0, 0, 1, 5, 1, 0, 0, BR,  0);
      step("jump",       1, 0, 0, 0, 1, 0, 0, 0, 0, 0, JMP, 0);
      step("jump_lu",    1, 5, 0, 0, 1, 1, 5, 0, 0, 0, JMP, 0);
      for (int i = 0; i < 3; i++)
         step("mwait",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0);
      step("mrelease",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, 0);
      step("after_rel",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
      step("rdy_noacc",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 0);
      for (int i = 0; i < 2; i++)
         step("frz_br",  1, 0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ, 0);
      step("rel_br",     1, 0, 0, 0, 0, 0, 0, 1, 1, 1, BR,  0);
      step("idle2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);

      for (int i = 0; i < 5; i++)
         step("to_wait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0);
      for (int i = 0; i < 20; i++)
         step("to_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 1);
      step("to_reset",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 1);
      step("post_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);

      for (int i = 0; i < 300; i++)
         step("sat",     1, 5, 0, 0, 0, 1, 5, 0, 0, 0, LU,  0);
      step("sat_hold",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);

      for (int i = 0; i < 3; i++)
         step("mid_wait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0);
      step("mid_rst",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST, 0);
      for (int i = 0; i < 5; i++)
         step("rewait",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0);
      step("re_to",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1);

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath; decides per cycle whether each pipeline register advances, holds, or is bubbled/flushed.
- Covers three cases:
  - load-use stalls;
  - taken-branch/jump squashes;
  - multi-cycle data-memory waits, with a timeout error state.
- Consumes decoded control bits already produced per stage by ControlUnit (MemRead, MemWrite, Branch, Jump) plus register fields; drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB write/flush enables.

Parameters:
- MEM_WAIT_MAX, 15, maximum consecutive MEM_WAIT cycles before entering TIMEOUT (legal range 1..255).
- CNT_W, 8, width of the stall_count performance counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt (R-type, beq, bne, sw).
- id_jump  input  1  Jump control bit of the ID instruction (opcode 2).
- ex_mem_read  input  1  MemRead of the instruction in EX (lw, opcode 35).
- ex_rt  input  5  destination rt of the instruction in EX.
- ex_branch_taken  input  1  Branch asserted in EX and condition true (beq/bne).
- mem_access  input  1  MemRead or MemWrite of the instruction in MEM.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC loads its next value.
- ifid_write  output  1  IF/ID register loads.
- ifid_flush  output  1  IF/ID loads a NOP (takes priority over ifid_write).
- idex_hold  output  1  ID/EX keeps its contents.
- idex_bubble  output  1  ID/EX loads all-zero control bits.
- exmem_hold  output  1  EX/MEM keeps its contents.
- memwb_bubble  output  1  MEM/WB loads all-zero control bits.
- mem_timeout  output  1  sticky error flag, registered.
- stall_count  output  CNT_W  saturating count of cycles with pc_write=0, registered.

Behaviour:
- FSM states RUN, MEM_WAIT, TIMEOUT; wait_cnt is an 8-bit register.
- Control outputs are combinational (Mealy) from state and inputs. mem_timeout and stall_count are registered.
- Reset:
  - While rst_n=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1, idex_hold=0, exmem_hold=0.
  - At a clock edge with rst_n=0: state<=RUN, wait_cnt<=0, stall_count<=0, mem_timeout<=0.
  - Reset mid-wait or in TIMEOUT returns to RUN on that edge.
- Default in RUN (no hazard): pc_write=1, ifid_write=1, all flush/hold/bubble=0.
- Priority in RUN, highest first:
  1. Freeze, when mem_access=1 and mem_ready=0:
     - pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, memwb_bubble=1.
     - Next state MEM_WAIT, wait_cnt<=1.
     - Branch, jump and load-use are ignored this cycle; they re-evaluate when the freeze releases because stage contents are held.
  2. Taken branch, when ex_branch_taken=1:
     - pc_write=1 (target), ifid_flush=1, idex_bubble=1.
     - Load-use and jump in ID are ignored (that instruction is squashed).
  3. Jump, when id_jump=1: pc_write=1, ifid_flush=1. Load-use detection is suppressed for jumps.
  4. Load-use, when ex_mem_read=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)):
     - pc_write=0, ifid_write=0, idex_bubble=1.
     - Exactly one bubble per load; next cycle the load is in MEM and the hazard clears.
- MEM_WAIT:
  - mem_ready=0: same freeze outputs as priority 1.
    - If wait_cnt==MEM_WAIT_MAX: next state TIMEOUT.
    - Otherwise wait_cnt<=wait_cnt+1.
  - mem_ready=1: freeze released this cycle; RUN priority rules 2–4 apply combinationally; next state RUN, wait_cnt<=0.
  - mem_ready is sampled only when mem_access=1. In RUN, mem_ready with mem_access=0 has no effect.
- TIMEOUT:
  - Permanent freeze outputs.
  - mem_timeout<=1 on entry and stays 1 until reset.
  - Exits only via rst_n.
- stall_count: increments at each edge where rst_n=1 and pc_write=0. Saturates at 2^CNT_W-1 with no wrap.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1; next cycle (ex_mem_read=0) all defaults; stall_count=1. Repeat with ex_rt=0 -> no stall.
- rt match gating: ex_rt=7=id_rt, id_rs=3, id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
- Branch over load-use: ex_branch_taken=1 together with a load-use match -> pc_write=1, ifid_flush=1, idex_bubble=1, stall_count unchanged. id_jump=1 alone -> ifid_flush=1, pc_write=1, idex_bubble=0.
- Memory wait: mem_access=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> freeze outputs for 3 cycles; release cycle pc_write=1; state back in RUN; stall_count=3.
- Freeze vs branch: mem_access=1, mem_ready=0 with ex_branch_taken=1 -> freeze only, ifid_flush=0; after ready, ifid_flush=1 in the release cycle.
- Timeout and reset: MEM_WAIT_MAX=4, mem_ready held 0 -> mem_timeout=1 after the 5th frozen edge, stays 1 for 20 more cycles. rst_n=0 for one edge -> mem_timeout=0, stall_count=0, RUN defaults. Run stall_count past 255 -> holds at 255.
